// File: rtl/data_memory_rsp.sv
// data_memory_rsp: responder side of the dcache line interface.
// Models off-chip data memory: takes one line read or write, completes it
// after LATENCY clock edges (accept edge counted as the first) and
// signals completion with a one-cycle mem_ack_o pulse.
//
// Handshake: the initiator raises mem_enable_i with write/addr/data and
// holds them until mem_ack_o. The request is accepted at the first edge
// that sees mem_enable_i=1 in IDLE; the responder works only from the
// values latched at that edge. mem_enable_i seen during ACK is not a new
// request; a held enable is accepted again at the edge after ACK.
//
// Optional feature macro: DMEM_PROTOCOL_CHECK_EN adds the sticky
// proto_err_o output, flagging initiator stability violations during WAIT.
module data_memory_rsp #(
    parameter int LINE_BITS   = 256,
    parameter int DEPTH_LINES = 512,
    parameter int LATENCY     = 10,
    parameter int ADDR_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mem_enable_i,
    input  logic                 mem_write_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [LINE_BITS-1:0] mem_data_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_ack_o
`ifdef DMEM_PROTOCOL_CHECK_EN
    ,
    output logic                 proto_err_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    // Counter only ever holds LATENCY-1 down to 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;

    logic                 lat_write;
    logic [IDX_W-1:0]     lat_idx;
    logic [LINE_BITS-1:0] lat_data;

    logic [IDX_W-1:0]     req_idx;

    logic                 accept;
    logic                 commit;
    logic                 commit_write;
    logic [IDX_W-1:0]     commit_idx;
    logic [LINE_BITS-1:0] commit_data;

    logic [LINE_BITS-1:0] mem [DEPTH_LINES];

    // Line index sits just above the 32-byte offset; upper bits alias.
    assign req_idx   = mem_addr_i[5 +: IDX_W];
    assign mem_ack_o = (state == ACK);

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic [ADDR_W-1:0] lat_addr;
`else
    // Offset and alias bits of the address play no part in the default build.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[4:0], mem_addr_i[ADDR_W-1:5+IDX_W]};
`endif

    // Next-state, counter and commit decode; commit marks the edge entering ACK.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        accept       = 1'b0;
        commit       = 1'b0;
        commit_write = lat_write;
        commit_idx   = lat_idx;
        commit_data  = lat_data;
        case (state)
            IDLE: begin
                if (mem_enable_i) begin
                    accept   = 1'b1;
                    cnt_next = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // Single-edge latency: commit straight from the live inputs.
                        state_next   = ACK;
                        commit       = 1'b1;
                        commit_write = mem_write_i;
                        commit_idx   = req_idx;
                        commit_data  = mem_data_i;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = ACK;
                    commit     = 1'b1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter, request latch and read-data register; reset aborts any transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_idx    <= '0;
            lat_data   <= '0;
            mem_data_o <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_write <= mem_write_i;
                lat_idx   <= req_idx;
                lat_data  <= mem_data_i;
            end
            if (commit && !commit_write) begin
                mem_data_o <= mem[commit_idx];
            end
        end
    end

    // Line array write at the edge entering ACK; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (commit && commit_write) begin
            mem[commit_idx] <= commit_data;
        end
    end

`ifdef DMEM_PROTOCOL_CHECK_EN
    // Full request address kept so any change during WAIT can be detected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_addr <= '0;
        end else if (accept) begin
            lat_addr <= mem_addr_i;
        end
    end

    // Sticky flag: initiator dropped or changed its request while waiting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            proto_err_o <= 1'b0;
        end else if (state == WAIT &&
                     (!mem_enable_i || mem_write_i != lat_write || mem_addr_i != lat_addr)) begin
            proto_err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_rsp.sv
// tb_data_memory_rsp: directed bench for data_memory_rsp.
// Two instances share clock, reset, write/addr/data: u10 (LATENCY=10) and
// u1 (LATENCY=1), each with its own enable. Inputs change at negedge or
// #1 after posedge; outputs are sampled #1 after posedge.
module tb_data_memory_rsp;

    logic         clk;
    logic         rst;
    logic         en10;
    logic         en1;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] rdata10;
    logic [255:0] rdata1;
    logic         ack10;
    logic         ack1;
`ifdef DMEM_PROTOCOL_CHECK_EN
    logic         perr10;
    logic         perr1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_rsp #(.LATENCY(10)) u10 (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_enable_i (en10),
        .mem_write_i  (mem_write),
        .mem_addr_i   (mem_addr),
        .mem_data_i   (mem_wdata),
        .mem_data_o   (rdata10),
        .mem_ack_o    (ack10)
`ifdef DMEM_PROTOCOL_CHECK_EN
        ,
        .proto_err_o  (perr10)
`endif
    );

    data_memory_rsp #(.LATENCY(1)) u1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_enable_i (en1),
        .mem_write_i  (mem_write),
        .mem_addr_i   (mem_addr),
        .mem_data_i   (mem_wdata),
        .mem_data_o   (rdata1),
        .mem_ack_o    (ack1)
`ifdef DMEM_PROTOCOL_CHECK_EN
        ,
        .proto_err_o  (perr1)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One request to the selected instance; edges counts the accept edge as 1.
    task automatic run_req(input bit on_l1, input logic w, input logic [31:0] a,
                           input logic [255:0] d, output int edges,
                           output logic [255:0] rdata);
        @(negedge clk);
        mem_write = w;
        mem_addr  = a;
        mem_wdata = d;
        if (on_l1) en1 = 1'b1;
        else       en10 = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        while (!(on_l1 ? ack1 : ack10) && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        rdata = on_l1 ? rdata1 : rdata10;
        en1  = 1'b0;
        en10 = 1'b0;
        @(posedge clk); #1;
        chk("ack_single_cycle", 256'(on_l1 ? ack1 : ack10), 256'(0));
    endtask

    initial begin
        logic [255:0] pat_a;
        logic [255:0] pat_d;
        logic [255:0] pat_b2b;
        logic [255:0] pat_x;
        logic [255:0] pat_l1;
        logic [255:0] rd;
        int           e;
        int           t1;
        int           ack_seen;

        pat_a   = {8{32'hA5A5_0001}};
        pat_d   = {8{32'h1357_9BDF}};
        pat_b2b = {4{64'hCAFE_F00D_0BAD_BEEF}};
        pat_x   = {8{32'hDEAD_0000}};
        pat_l1  = {16{16'h3C5A}};

        // Reset block
        rst       = 1'b1;
        en10      = 1'b0;
        en1       = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        #1;
        chk("reset_ack10", 256'(ack10), 256'(0));
        chk("reset_data10", rdata10, 256'(0));
        chk("reset_ack1", 256'(ack1), 256'(0));
        chk("reset_data1", rdata1, 256'(0));
`ifdef DMEM_PROTOCOL_CHECK_EN
        chk("reset_perr10", 256'(perr10), 256'(0));
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write then read one line, LATENCY=10
        run_req(1'b0, 1'b1, 32'h0000_0400, pat_a, e, rd);
        chk("wr400_latency", 256'(e), 256'(10));
        chk("wr400_data_unchanged", rdata10, 256'(0));
        run_req(1'b0, 1'b0, 32'h0000_0400, '0, e, rd);
        chk("rd400_latency", 256'(e), 256'(10));
        chk("rd400_data", rd, pat_a);

        // Aliasing: 0x4020, 0x0020, 0x403F all hit line 1
        run_req(1'b0, 1'b1, 32'h0000_4020, pat_d, e, rd);
        run_req(1'b0, 1'b0, 32'h0000_0020, '0, e, rd);
        chk("alias_rd0020", rd, pat_d);
        run_req(1'b0, 1'b0, 32'h0000_403F, '0, e, rd);
        chk("alias_rd403f", rd, pat_d);
        run_req(1'b0, 1'b0, 32'h0000_0400, '0, e, rd);
        chk("rd400_untouched", rd, pat_a);

        // Write to another line leaves mem_data_o at its last read value
        run_req(1'b0, 1'b1, 32'h0000_0C00, pat_x, e, rd);
        chk("data_held_after_write", rd, pat_a);

        // Back-to-back with enable held: write then read of line 0x800
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 32'h0000_0800;
        mem_wdata = pat_b2b;
        en10      = 1'b1;
        e = 0;
        do begin
            @(posedge clk); #1;
            e++;
        end while (!ack10 && e < 60);
        t1 = e;
        mem_write = 1'b0;
        do begin
            @(posedge clk); #1;
            e++;
        end while (!ack10 && e < 60);
        chk("b2b_ack_spacing", 256'(e - t1), 256'(11));
        chk("b2b_read_data", rdata10, pat_b2b);
        en10 = 1'b0;
        @(posedge clk); #1;
        chk("b2b_ack_single", 256'(ack10), 256'(0));

        // LATENCY=1 instance
        run_req(1'b1, 1'b1, 32'h0000_0040, pat_l1, e, rd);
        chk("l1_wr_latency", 256'(e), 256'(1));
        run_req(1'b1, 1'b0, 32'h0000_0040, '0, e, rd);
        chk("l1_rd_latency", 256'(e), 256'(1));
        chk("l1_rd_data", rd, pat_l1);

        // Reset during a read in WAIT: outputs clear immediately, no ack later
        @(negedge clk);
        mem_write = 1'b0;
        mem_addr  = 32'h0000_0020;
        en10      = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b1;
        en10 = 1'b0;
        #1;
        chk("midrd_reset_ack", 256'(ack10), 256'(0));
        chk("midrd_reset_data", rdata10, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        ack_seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ack10) ack_seen++;
        end
        chk("midrd_no_late_ack", 256'(ack_seen), 256'(0));

        // Reset during a write in WAIT: the line keeps its old contents
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 32'h0000_0400;
        mem_wdata = pat_x;
        en10      = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst  = 1'b1;
        en10 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_req(1'b0, 1'b0, 32'h0000_0400, '0, e, rd);
        chk("midwr_aborted", rd, pat_a);

`ifdef DMEM_PROTOCOL_CHECK_EN
        // Address change during WAIT: sticky error, read uses latched line 0x100
        run_req(1'b0, 1'b1, 32'h0000_0100, pat_d, e, rd);
        run_req(1'b0, 1'b1, 32'h0000_0140, pat_x, e, rd);
        chk("perr_clean_before", 256'(perr10), 256'(0));
        @(negedge clk);
        mem_write = 1'b0;
        mem_addr  = 32'h0000_0100;
        en10      = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_addr = 32'h0000_0140;
        e = 0;
        do begin
            @(posedge clk); #1;
            e++;
        end while (!ack10 && e < 40);
        chk("perr_ack_seen", 256'(ack10), 256'(1));
        chk("perr_read_latched", rdata10, pat_d);
        chk("perr_set", 256'(perr10), 256'(1));
        en10 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("perr_sticky", 256'(perr10), 256'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
